// File: rtl/range_parser.sv
// range_parser: streams an ASCII list "a-b,c-d,..." and emits
// one decoded (start, end) pair per range over a valid/ready port.
module range_parser #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_char,
    input  logic                  in_valid,
    input  logic                  in_eof,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] range_start,
    output logic [DATA_WIDTH-1:0] range_end,
    output logic [DATA_WIDTH-1:0] start_digs,
    output logic [DATA_WIDTH-1:0] end_digs,
    output logic                  range_valid,
    input  logic                  range_ready,
    output logic                  range_last,
    output logic [15:0]           range_count,
    output logic                  done,
    output logic                  err
);

    localparam int PW = DATA_WIDTH + 4;

    typedef enum logic [2:0] {
        S_START, S_END, S_EMIT, S_DONE, S_ERR
    } state_t;

    state_t state, state_nx;

    logic                  accept;
    logic                  hs;
    logic                  is_digit;
    logic                  is_cr;
    logic                  is_dash;
    logic                  is_sep;
    logic [3:0]            dig;
    logic [DATA_WIDTH-1:0] acc_cur;
    logic [PW-1:0]         acc_w;
    logic [PW-1:0]         prod;
    logic                  ovf;

    // Token classification and the widened next-accumulator value.
    always_comb begin
        accept   = in_valid && in_ready;
        hs       = range_valid && range_ready;
        is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);
        is_cr    = (in_char == 8'h0D);
        is_dash  = (in_char == 8'h2D);
        is_sep   = (in_char == 8'h2C) || (in_char == 8'h0A);
        dig      = in_char[3:0];
        acc_cur  = (state == S_END) ? range_end : range_start;
        acc_w    = {4'b0, acc_cur};
        prod     = (acc_w << 3) + (acc_w << 1) + PW'(dig);
        ovf      = |prod[PW-1:DATA_WIDTH];
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_START;
        else        state <= state_nx;
    end

    // Next-state decode; eof takes priority over in_char.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_START: begin
                if (accept) begin
                    if (in_eof) begin
                        state_nx = (start_digs == '0) ? S_DONE : S_ERR;
                    end else if (is_digit) begin
                        if (ovf) state_nx = S_ERR;
                    end else if (is_dash) begin
                        state_nx = (start_digs != '0) ? S_END : S_ERR;
                    end else if (is_sep) begin
                        if (start_digs != '0) state_nx = S_ERR;
                    end else if (!is_cr) begin
                        state_nx = S_ERR;
                    end
                end
            end
            S_END: begin
                if (accept) begin
                    if (in_eof || is_sep) begin
                        if (end_digs != '0 && range_start <= range_end)
                            state_nx = S_EMIT;
                        else
                            state_nx = S_ERR;
                    end else if (is_digit) begin
                        if (ovf) state_nx = S_ERR;
                    end else if (!is_cr) begin
                        state_nx = S_ERR;
                    end
                end
            end
            S_EMIT: begin
                if (hs) state_nx = range_last ? S_DONE : S_START;
            end
            default: state_nx = state;
        endcase
    end

    // Outputs that follow the state directly.
    always_comb begin
        in_ready = (state == S_START) || (state == S_END);
        done     = (state == S_DONE);
        err      = (state == S_ERR);
    end

    // Accumulators, counters and the registered valid flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            range_start <= '0;
            range_end   <= '0;
            start_digs  <= '0;
            end_digs    <= '0;
            range_last  <= 1'b0;
            range_count <= '0;
            range_valid <= 1'b0;
        end else begin
            if (accept && !in_eof && is_digit && !ovf) begin
                if (state == S_START) begin
                    range_start <= prod[DATA_WIDTH-1:0];
                    start_digs  <= start_digs + DATA_WIDTH'(1);
                end else begin
                    range_end <= prod[DATA_WIDTH-1:0];
                    end_digs  <= end_digs + DATA_WIDTH'(1);
                end
            end
            if (state == S_END && state_nx == S_EMIT)
                range_last <= in_eof;
            if (hs) begin
                range_start <= '0;
                range_end   <= '0;
                start_digs  <= '0;
                end_digs    <= '0;
                range_count <= range_count + 16'd1;
            end
            // Valid rises one cycle after entering S_EMIT.
            range_valid <= (state == S_EMIT) && !hs;
        end
    end

endmodule

// File: tb/tb_range_parser.sv
// tb_range_parser: vector table, directed corner sequences and
// randomized streams checked against a string-level reference model.
module tb_range_parser;

    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    in_char = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_eof = 1'b0;
    logic          in_ready;
    logic [DW-1:0] range_start;
    logic [DW-1:0] range_end;
    logic [DW-1:0] start_digs;
    logic [DW-1:0] end_digs;
    logic          range_valid;
    logic          range_ready = 1'b1;
    logic          range_last;
    logic [15:0]   range_count;
    logic          done;
    logic          err;

    range_parser #(.DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .in_char(in_char), .in_valid(in_valid), .in_eof(in_eof),
        .in_ready(in_ready),
        .range_start(range_start), .range_end(range_end),
        .start_digs(start_digs), .end_digs(end_digs),
        .range_valid(range_valid), .range_ready(range_ready),
        .range_last(range_last), .range_count(range_count),
        .done(done), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        longint unsigned s;
        longint unsigned e;
        longint unsigned sd;
        longint unsigned ed;
        bit              last;
    } rng_t;

    typedef struct {
        string           s;
        bit              eof;
        int              n;
        bit              err;
        bit              done;
        longint unsigned s0;
        longint unsigned e0;
        int              sd0;
        int              ed0;
        bit              lastl;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    rng_t got[$];
    rng_t exp_q[$];
    bit   exp_err;
    bit   exp_done;
    bit   rr_random = 1'b0;
    bit   rr_val = 1'b1;
    rng_t held;
    bit   held_v = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Downstream ready, changed just after each rising edge.
    always @(posedge clock) begin
        #1;
        range_ready = rr_random ? 1'($urandom_range(0, 1)) : rr_val;
    end

    // Handshake capture, hold-stability and valid/ready exclusion.
    always @(negedge clock) begin
        if (!reset) begin
            held_v = 1'b0;
        end else begin
            if (range_valid) chk("in_ready_with_valid", in_ready, 0);
            if (held_v && range_valid) begin
                chk("hold_start", range_start, held.s);
                chk("hold_end", range_end, held.e);
                chk("hold_last", range_last, held.last);
            end
            held = '{range_start, range_end, start_digs, end_digs,
                     range_last};
            held_v = range_valid && !range_ready;
            if (range_valid && range_ready) got.push_back(held);
        end
    end

    task automatic do_reset();
        @(negedge clock);
        in_valid = 1'b0;
        in_eof = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valid", range_valid, 0);
        chk("rst_start", range_start, 0);
        chk("rst_end", range_end, 0);
        chk("rst_digs", start_digs | end_digs, 0);
        chk("rst_count", range_count, 0);
        chk("rst_last", range_last, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clock);
        reset = 1'b1;
        got.delete();
    endtask

    task automatic feed(string s, bit eof);
        int n = s.len() + (eof ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            @(negedge clock);
            while (!in_ready && !err && !done && t < 100) begin
                @(negedge clock);
                t++;
            end
            if (err || done) break;
            if (t >= 100) begin
                chk("feed_timeout", t, 0);
                break;
            end
            in_valid = 1'b1;
            in_eof = (i == s.len());
            in_char = in_eof ? 8'd0 : s[i];
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            in_eof = 1'b0;
        end
    endtask

    task automatic settle();
        rr_random = 1'b0;
        rr_val = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    // Reference: walk the text, splitting numbers at '-' and
    // terminators, with overflow judged by plain 64-bit arithmetic.
    task automatic model(string s, bit eof);
        longint unsigned acc[2];
        longint unsigned dg[2];
        int side;
        int n;
        exp_q.delete();
        exp_err = 1'b0;
        exp_done = 1'b0;
        acc = '{0, 0};
        dg = '{0, 0};
        side = 0;
        n = s.len() + (eof ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            bit is_eof;
            byte unsigned c;
            longint unsigned dd;
            is_eof = (i == s.len());
            c = is_eof ? 8'd0 : s[i];
            if (!is_eof && c >= 8'h30 && c <= 8'h39) begin
                dd = longint'(c) - 48;
                if (acc[side] > (64'hFFFF_FFFF_FFFF_FFFF - dd) / 10) begin
                    exp_err = 1'b1;
                    return;
                end
                acc[side] = acc[side] * 10 + dd;
                dg[side]++;
            end else if (!is_eof && c == 8'd13) begin
                dd = 0;
            end else if (!is_eof && c == 8'h2D) begin
                if (side == 0 && dg[0] != 0) begin
                    side = 1;
                end else begin
                    exp_err = 1'b1;
                    return;
                end
            end else if (is_eof || c == 8'h2C || c == 8'd10) begin
                if (side == 0) begin
                    if (dg[0] != 0) begin
                        exp_err = 1'b1;
                        return;
                    end
                    if (is_eof) begin
                        exp_done = 1'b1;
                        return;
                    end
                end else begin
                    if (dg[1] == 0 || acc[0] > acc[1]) begin
                        exp_err = 1'b1;
                        return;
                    end
                    exp_q.push_back('{acc[0], acc[1], dg[0], dg[1], is_eof});
                    acc = '{0, 0};
                    dg = '{0, 0};
                    side = 0;
                    if (is_eof) begin
                        exp_done = 1'b1;
                        return;
                    end
                end
            end else begin
                exp_err = 1'b1;
                return;
            end
        end
    endtask

    function automatic string gen();
        string s = "";
        int k = $urandom_range(1, 4);
        for (int j = 0; j < k; j++) begin
            longint unsigned a;
            longint unsigned b;
            int m = $urandom_range(0, 9);
            a = $urandom_range(0, 999);
            b = a + $urandom_range(0, 500);
            if (m == 0) begin
                a = {$urandom, $urandom};
                b = a + $urandom_range(0, 3);
            end
            if (m == 1) b = (a > 0) ? a - 1 : 0;
            if (m == 2) s = {s, "18446744073709551616-1"};
            else s = {s, $sformatf("%0d-%0d", a, b)};
            if (j < k - 1 || $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0: s = {s, ","};
                    1: s = {s, "\n"};
                    2: s = {s, "\r\n"};
                    default: s = {s, ",,"};
                endcase
            end
            if ($urandom_range(0, 24) == 0) s = {s, "x"};
            if ($urandom_range(0, 24) == 0) s = {s, "-"};
        end
        return s;
    endfunction

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{"11-22,", 0, 1, 0, 0, 11, 22, 2, 2, 0};
        vecs[1]  = '{"95-115\n", 1, 1, 0, 1, 95, 115, 2, 3, 0};
        vecs[2]  = '{"18446744073709551616-", 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{"5-3,", 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{"-5", 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{"1-2,\r\n,3-4", 1, 2, 0, 1, 1, 2, 1, 1, 1};
        vecs[6]  = '{"18446744073709551615-18446744073709551615,", 0, 1,
                     0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_FFFF_FFFF, 20, 20, 0};
        vecs[7]  = '{"", 1, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[8]  = '{"7-9", 1, 1, 0, 1, 7, 9, 1, 1, 1};
        vecs[9]  = '{"1-2x", 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{"3-", 1, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{"3,", 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{"007-10\r,", 0, 1, 0, 0, 7, 10, 3, 2, 0};

        for (int i = 0; i < 13; i++) begin
            rr_random = (i % 2 == 1);
            do_reset();
            feed(vecs[i].s, vecs[i].eof);
            settle();
            chk($sformatf("v%0d_n", i), got.size(), vecs[i].n);
            chk($sformatf("v%0d_err", i), err, vecs[i].err);
            chk($sformatf("v%0d_done", i), done, vecs[i].done);
            chk($sformatf("v%0d_count", i), range_count, vecs[i].n);
            if (vecs[i].n > 0 && got.size() > 0) begin
                chk($sformatf("v%0d_s0", i), got[0].s, vecs[i].s0);
                chk($sformatf("v%0d_e0", i), got[0].e, vecs[i].e0);
                chk($sformatf("v%0d_sd0", i), got[0].sd, vecs[i].sd0);
                chk($sformatf("v%0d_ed0", i), got[0].ed, vecs[i].ed0);
                chk($sformatf("v%0d_last", i), got[got.size()-1].last,
                    vecs[i].lastl);
            end
        end

        // Latency and hold while downstream stalls.
        rr_random = 1'b0;
        rr_val = 1'b0;
        do_reset();
        feed("7-9", 1);
        chk("lat_edge_n", range_valid, 0);
        @(posedge clock);
        #2;
        chk("lat_edge_n1", range_valid, 1);
        repeat (5) begin
            @(negedge clock);
            chk("stall_valid", range_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_start", range_start, 7);
            chk("stall_end", range_end, 9);
            chk("stall_last", range_last, 1);
        end
        rr_val = 1'b1;
        begin
            int t = 0;
            while (range_valid && t < 6) begin
                @(negedge clock);
                t++;
            end
        end
        chk("hs_valid_drop", range_valid, 0);
        chk("hs_last", range_last, 1);
        chk("hs_count", range_count, 1);
        chk("hs_done", done, 1);
        chk("hs_emits", got.size(), 1);

        // Reset mid-number discards the partial value.
        settle();
        do_reset();
        feed("12", 0);
        chk("partial_digs", start_digs, 2);
        do_reset();
        feed("7-9,", 0);
        settle();
        chk("rst_mid_emits", got.size(), 1);
        if (got.size() > 0) begin
            chk("rst_mid_s", got[0].s, 7);
            chk("rst_mid_e", got[0].e, 9);
            chk("rst_mid_sd", got[0].sd, 1);
            chk("rst_mid_ed", got[0].ed, 1);
        end

        // Reset while a range is pending drops it.
        rr_val = 1'b0;
        do_reset();
        feed("4-5,", 0);
        repeat (3) @(negedge clock);
        chk("emit_pending", range_valid, 1);
        do_reset();
        settle();
        chk("emit_drop_valid", range_valid, 0);
        chk("emit_drop_count", range_count, 0);
        chk("emit_drop_emits", got.size(), 0);

        // Randomized streams against the reference model.
        for (int it = 0; it < 40; it++) begin
            string s;
            bit eof;
            int nm;
            s = gen();
            eof = ($urandom_range(0, 4) != 0);
            model(s, eof);
            rr_random = 1'b1;
            do_reset();
            feed(s, eof);
            settle();
            chk($sformatf("r%0d_n", it), got.size(), exp_q.size());
            chk($sformatf("r%0d_err", it), err, exp_err);
            chk($sformatf("r%0d_done", it), done, exp_done);
            chk($sformatf("r%0d_count", it), range_count, exp_q.size());
            nm = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
            for (int j = 0; j < nm; j++) begin
                chk($sformatf("r%0d_%0d_s", it, j), got[j].s, exp_q[j].s);
                chk($sformatf("r%0d_%0d_e", it, j), got[j].e, exp_q[j].e);
                chk($sformatf("r%0d_%0d_sd", it, j), got[j].sd, exp_q[j].sd);
                chk($sformatf("r%0d_%0d_ed", it, j), got[j].ed, exp_q[j].ed);
                chk($sformatf("r%0d_%0d_last", it, j), got[j].last,
                    exp_q[j].last);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/range_parser.md
RANGE_PARSER -- requirements
Module: range_parser

Interface
REQ-001 Parameter: DATA_WIDTH, default 64, width of parsed bound values and digit counts.
REQ-002 clock  input  1  rising-edge clock; the block has exactly one clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_char  input  8  ASCII byte of the range list, format "a-b,c-d,...".
REQ-005 in_valid  input  1  in_char or in_eof is valid this cycle.
REQ-006 in_eof  input  1  end-of-stream token, qualified by in_valid; in_char is ignored when set.
REQ-007 in_ready  output  1  block accepts a token this cycle.
REQ-008 range_start  output  DATA_WIDTH  parsed lower bound.
REQ-009 range_end  output  DATA_WIDTH  parsed upper bound.
REQ-010 start_digs  output  DATA_WIDTH  decimal digit count of range_start.
REQ-011 end_digs  output  DATA_WIDTH  decimal digit count of range_end.
REQ-012 range_valid  output  1  range outputs valid.
REQ-013 range_ready  input  1  downstream accepts the range.
REQ-014 range_last  output  1  current range was terminated by in_eof.
REQ-015 range_count  output  16  number of ranges handed off since reset.
REQ-016 done  output  1  stream fully consumed without error.
REQ-017 err  output  1  sticky parse error.

Function
REQ-018 Token accept SHALL occur when in_valid && in_ready; in_ready SHALL be 1 only in states S_START and S_END.
REQ-019 States SHALL be S_START, S_END, S_EMIT, S_DONE and S_ERR.
REQ-020 S_START, digit d: start = start*10+d, start_digs += 1.
REQ-021 S_START, '-': with start_digs>0 go to S_END; with start_digs==0 go to S_ERR.
REQ-022 S_START with start_digs==0: ',' and LF (10) SHALL be ignored, and in_eof SHALL go to S_DONE.
REQ-023 S_START with start_digs>0: ',', LF or in_eof SHALL go to S_ERR.
REQ-024 S_END, digit d: end = end*10+d, end_digs += 1.
REQ-025 S_END, ',', LF or in_eof: with end_digs>0 go to S_EMIT; with end_digs==0 go to S_ERR.
REQ-026 The S_END terminator SHALL set range_last = 1 for in_eof and 0 otherwise.
REQ-027 CR (13) SHALL be accepted and ignored in S_START and S_END; any other non-digit byte SHALL go to S_ERR.
REQ-028 Any digit whose accumulation exceeds 2^DATA_WIDTH-1 SHALL go to S_ERR; detect with a widened product, no wrap-around.
REQ-029 An S_END terminator with start > end SHALL go to S_ERR instead of S_EMIT.
REQ-030 Latency: terminator accepted at edge N -> range_valid = 1 after edge N+1 (one registered cycle).
REQ-031 In S_EMIT, range_valid = 1 and all range outputs SHALL be held stable until range_ready.
REQ-032 On handshake range_valid && range_ready: clear accumulators and digit counts, range_count += 1 (wraps at 2^16).
REQ-033 After handshake, next state SHALL be S_DONE if range_last, else S_START.
REQ-034 range_valid SHALL drop in the cycle after handshake; no back-to-back emits.
REQ-035 S_DONE: done = 1 and in_ready = 0, held until reset.
REQ-036 S_ERR: err = 1, in_ready = 0 and range_valid = 0, held until reset.
REQ-037 range_valid SHALL never be 1 in the same cycle as in_ready.

Reset
REQ-038 While reset = 0 (asynchronous), state = S_START and all outputs SHALL be 0 except in_ready = 1.
REQ-039 Reset asserted mid-number or in S_EMIT SHALL discard the partial or pending range, with no emit.

Verification
REQ-040 "11-22," with range_ready = 1 -> one emit: 11, 22, digs 2/2, range_last = 0, then range_count = 1.
REQ-041 "95-115\n" then in_eof -> emit 95, 115, digs 2/3, last = 0; then done = 1, range_count = 1.
REQ-042 "7-9" then in_eof, range_ready low for 5 cycles -> outputs stable and in_ready = 0 throughout; after handshake range_last = 1, then done = 1.
REQ-043 "18446744073709551616-" (DATA_WIDTH 64) -> err = 1 on the final digit, no emit; "5-3," -> err = 1; "-5" -> err = 1.
REQ-044 "12", then reset pulse, then "7-9," -> emit 7, 9, digs 1/1; digits "12" are absent from the result.
REQ-045 "1-2,\r\n,3-4" then in_eof -> two emits, (1,2) and (3,4); second has range_last = 1; range_count = 2; err = 0.
